// File: rtl/pc_fetch_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_if
//
// IF-stage fetch unit. Owns the architectural PC, issues instruction-memory
// reads one at a time, and loads the IF/ID register {instr, pc4, if_valid}
// that feeds decode. It consumes the EX-stage redirect (pc_src, baddr) and
// the hazard-unit stall.
//
// Parameters
//   RESET_PC     PC loaded on reset (word aligned; low bits are forced to 0)
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous, active-high reset (overrides every other input)
//   pc_src       EX redirect request (taken branch), single-cycle pulse
//   baddr        redirect target; bits [1:0] are ignored
//   stall        hold IF/ID contents and do not advance the PC
//   imem_req     read request, high only while in FETCH
//   imem_addr    read address, always equal to the PC register
//   imem_rvalid  read data valid, exactly one pulse per accepted request
//   imem_rdata   instruction word, qualified by imem_rvalid
//   instr        IF/ID instruction
//   pc4          IF/ID fetched pc + 4
//   if_valid     IF/ID holds a real instruction (0 = bubble)
//   state_dbg    current fetch FSM state (FETCH=0, WAIT=1, HOLD=2, DRAIN=3)
//
// Memory handshake:
//   The memory accepts every request; there is no ready signal. imem_req is
//   high for exactly one cycle (FETCH always advances), which launches one
//   read of imem_addr. The memory answers with a single imem_rvalid pulse,
//   with imem_rdata valid in that cycle, at least one cycle later. Because
//   no new request is issued until the response has been seen, at most one
//   read is ever in flight.
// ---------------------------------------------------------------------------
module pc_fetch_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_src,
  input  logic [31:0] baddr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        if_valid,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request issued this cycle
    ST_WAIT  = 2'd1,  // waiting for the response to our request
    ST_HOLD  = 2'd2,  // response parked in the skid buffer behind a stall
    ST_DRAIN = 2'd3   // waiting for a response that a redirect made stale
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // The skid buffer holds a word only while in HOLD, so the state itself
  // doubles as the buffer's occupancy flag.
  logic [31:0] skid_data;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  // Wraps modulo 2^32, so 0xFFFF_FFFC steps to 0.
  assign pc_plus4    = pc + 32'd4;
  // Masking (rather than slicing) keeps the PC word aligned whatever the
  // low bits of the branch target are.
  assign redirect_pc = baddr & 32'hFFFF_FFFC;

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC & 32'hFFFF_FFFC;
      state     <= ST_FETCH;
      instr     <= 32'd0;
      pc4       <= 32'd0;
      if_valid  <= 1'b0;
      skid_data <= 32'd0;
    end else if (pc_src) begin
      // A redirect beats both stall and any response arriving this cycle:
      // the fetched path is wrong, so flush IF/ID and restart at the target.
      pc       <= redirect_pc;
      instr    <= 32'd0;
      if_valid <= 1'b0;
      case (state)
        // The request issued this cycle is still outstanding.
        ST_FETCH: state <= ST_DRAIN;
        // A response arriving now is the one we were waiting for; dropping
        // it leaves nothing in flight. Otherwise it must still be drained.
        ST_WAIT:  state <= imem_rvalid ? ST_FETCH : ST_DRAIN;
        // Buffered word is simply abandoned.
        ST_HOLD:  state <= ST_FETCH;
        // Keep draining; if the stale response lands in this same cycle it
        // is consumed here, otherwise DRAIN would wait forever.
        ST_DRAIN: state <= imem_rvalid ? ST_FETCH : ST_DRAIN;
        default:  state <= ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          // Any rvalid here cannot belong to us; nothing is in flight yet.
          state <= ST_WAIT;
          if (!stall) if_valid <= 1'b0;
        end

        ST_WAIT: begin
          if (imem_rvalid) begin
            if (stall) begin
              // Decode cannot take it yet: park the word and keep IF/ID.
              skid_data <= imem_rdata;
              state     <= ST_HOLD;
            end else begin
              instr    <= imem_rdata;
              pc4      <= pc_plus4;
              if_valid <= 1'b1;
              pc       <= pc_plus4;
              state    <= ST_FETCH;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end

        ST_HOLD: begin
          // PC still points at the buffered word, so pc + 4 is its pc4.
          if (!stall) begin
            instr    <= skid_data;
            pc4      <= pc_plus4;
            if_valid <= 1'b1;
            pc       <= pc_plus4;
            state    <= ST_FETCH;
          end
        end

        ST_DRAIN: begin
          // The stale word is dropped; PC already holds the redirect target.
          if (imem_rvalid) state <= ST_FETCH;
          if (!stall) if_valid <= 1'b0;
        end

        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_if.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_if
//
// Bench for pc_fetch_if. A memory responder answers each request after a
// configurable (or random) latency with a word derived from the address.
// A transaction-level model tracks the PC, whether a read is outstanding
// (and whether it has been made stale by a redirect), whether a word is
// parked behind a stall, and the IF/ID contents; a negedge compare process
// checks every DUT output against it each cycle. Directed phases pin the
// model with hand-computed literal expectations, then a long random run
// mixes stalls, redirects, resets and latencies.
// ---------------------------------------------------------------------------
module tb_pc_fetch_if;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] baddr = 32'd0;
  logic        stall = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic        if_valid;
  logic [1:0]  state_dbg;

  pc_fetch_if #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_src     (pc_src),
    .baddr      (baddr),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .pc4        (pc4),
    .if_valid   (if_valid),
    .state_dbg  (state_dbg)
  );

  // ---------------- counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a scrambled function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc    = RESET_PC;
  logic        m_busy  = 1'b0;   // a read is in flight
  logic        m_stale = 1'b0;   // the in-flight read belongs to an abandoned path
  logic        m_have  = 1'b0;   // a fetched word is parked behind a stall
  logic [31:0] m_word  = 32'd0;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_pc4   = 32'd0;
  logic        m_valid = 1'b0;
  logic        m_loaded = 1'b0;  // IF/ID took a new instruction at the last edge
  logic [63:0] exp_q[$];         // {pc4, instr} of every expected load

  function automatic logic m_req();
    return !m_busy && !m_have;
  endfunction

  task automatic m_load(input logic [31:0] w);
    m_instr  = w;
    m_pc4    = m_pc + 32'd4;
    m_valid  = 1'b1;
    m_pc     = m_pc + 32'd4;
    m_loaded = 1'b1;
    exp_q.push_back({m_pc4, m_instr});
  endtask

  task automatic model_tick(input bit r, input bit ps, input logic [31:0] ba,
                            input bit st, input bit rv);
    bit req_now;
    req_now  = m_req();
    m_loaded = 1'b0;
    if (r) begin
      m_pc = RESET_PC; m_busy = 0; m_stale = 0; m_have = 0;
      m_instr = 0; m_pc4 = 0; m_valid = 0;
      exp_q.delete();
    end else if (ps) begin
      m_pc = {ba[31:2], 2'b00}; m_valid = 0; m_instr = 0; m_have = 0;
      if (req_now) begin
        m_busy = 1; m_stale = 1;
      end else if (m_busy) begin
        if (rv) begin m_busy = 0; m_stale = 0; end
        else m_stale = 1;
      end
    end else if (req_now) begin
      m_busy = 1; m_stale = 0;
      if (!st) m_valid = 0;
    end else if (m_busy) begin
      if (rv && !m_stale) begin
        m_busy = 0;
        if (!st) m_load(mem_word(m_pc));
        else begin m_have = 1; m_word = mem_word(m_pc); end
      end else begin
        if (rv) begin m_busy = 0; m_stale = 0; end
        if (!st) m_valid = 0;
      end
    end else begin
      if (!st) begin m_load(m_word); m_have = 0; end
    end
  endtask

  // ---------------- memory responder ----------------
  int          lat_cfg  = 1;   // 0 = random latency 1..4 per request
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'd0;
  logic        s_req;
  logic [31:0] s_addr;

  // ---------------- driver ----------------
  // Applies one cycle of inputs, then advances model and memory at the edge.
  task automatic step(input bit r, input bit ps, input logic [31:0] ba, input bit st);
    bit rv;
    rv = (mem_cnt == 1);
    rst = r; pc_src = ps; baddr = ba; stall = st; imem_rvalid = rv;
    imem_rdata = rv ? mem_word(mem_addr) : $urandom;
    @(negedge clk);
    s_req  = imem_req;
    s_addr = imem_addr;
    @(posedge clk);
    model_tick(r, ps, ba, st, rv);
    if (mem_cnt > 0) mem_cnt--;
    if (r) mem_cnt = 0;
    else if (s_req) begin
      mem_cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
      mem_addr = s_addr;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 32'd0, 0);
  endtask

  task automatic run_until_req(input int max);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < max) begin
      idle();
      n++;
    end
    chk("wait_for_req", 32'(imem_req), 32'd1);
  endtask

  // ---------------- compare process (scoreboard) ----------------
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req",  32'(imem_req), 32'(m_req()));
      chk("imem_addr", imem_addr, m_pc);
      chk("instr",     instr, m_instr);
      chk("pc4",       pc4, m_pc4);
      chk("if_valid",  32'(if_valid), 32'(m_valid));
      if (m_loaded && exp_q.size() > 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_instr", instr, e[31:0]);
        chk("sb_pc4",   pc4,   e[63:32]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    step(1, 0, 32'd0, 0);
    step(1, 0, 32'd0, 0);
    chk_en = 1'b1;

    // Reset state
    chk("rst_req",   32'(imem_req), 32'd1);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc4",   pc4, 32'd0);

    // Sequential fetch, 1-cycle memory, no stall
    lat_cfg = 1;
    idle();
    chk("t1_wait_req", 32'(imem_req), 32'd0);
    idle();
    chk("t1_addr1",  imem_addr, 32'h4);
    chk("t1_pc4_1",  pc4, 32'h4);
    chk("t1_instr1", instr, mem_word(32'h0));
    chk("t1_valid1", 32'(if_valid), 32'd1);
    idle();
    chk("t1_bubble", 32'(if_valid), 32'd0);
    idle();
    chk("t1_addr2",  imem_addr, 32'h8);
    chk("t1_pc4_2",  pc4, 32'h8);
    idle(); idle();
    chk("t1_addr3",  imem_addr, 32'hC);
    chk("t1_pc4_3",  pc4, 32'hC);
    chk("t1_instr3", instr, mem_word(32'h8));

    // Response arrives under stall, stall held 3 cycles
    idle();                      // WAIT, response due this cycle
    step(0, 0, 32'd0, 1);        // rvalid with stall -> parked
    chk("t2_hold_req",   32'(imem_req), 32'd0);
    chk("t2_hold_pc4",   pc4, 32'hC);
    chk("t2_hold_instr", instr, mem_word(32'h8));
    step(0, 0, 32'd0, 1);
    step(0, 0, 32'd0, 1);
    chk("t2_still_req", 32'(imem_req), 32'd0);
    chk("t2_still_pc4", pc4, 32'hC);
    step(0, 0, 32'd0, 0);        // release
    chk("t2_rel_instr", instr, mem_word(32'hC));
    chk("t2_rel_pc4",   pc4, 32'h10);
    chk("t2_rel_valid", 32'(if_valid), 32'd1);
    chk("t2_rel_addr",  imem_addr, 32'h10);

    // Redirect before the response of a 3-cycle memory
    lat_cfg = 3;
    idle();                      // WAIT
    step(0, 1, 32'h100, 0);
    chk("t3_flush_valid", 32'(if_valid), 32'd0);
    chk("t3_flush_instr", instr, 32'd0);
    chk("t3_drain_req",   32'(imem_req), 32'd0);
    run_until_req(8);
    chk("t3_new_addr", imem_addr, 32'h100);
    idle(); idle(); idle(); idle();
    chk("t3_instr", instr, mem_word(32'h100));
    chk("t3_pc4",   pc4, 32'h104);

    // Redirect in the same cycle as rvalid with stall
    lat_cfg = 1;
    idle();                      // WAIT, response due this cycle
    step(0, 1, 32'h100, 1);
    chk("t4_req",   32'(imem_req), 32'd1);
    chk("t4_addr",  imem_addr, 32'h100);
    chk("t4_valid", 32'(if_valid), 32'd0);
    chk("t4_instr", instr, 32'd0);

    // Unaligned target at the top of the address space
    step(0, 1, 32'hFFFF_FFFF, 0); // from FETCH -> drain
    chk("t5_addr_masked", imem_addr, 32'hFFFF_FFFC);
    run_until_req(8);
    chk("t5_fetch_addr", imem_addr, 32'hFFFF_FFFC);
    idle(); idle();
    chk("t5_pc4_wrap",  pc4, 32'h0);
    chk("t5_addr_wrap", imem_addr, 32'h0);
    chk("t5_instr",     instr, mem_word(32'hFFFF_FFFC));

    // Reset mid-WAIT together with a redirect
    idle();                      // WAIT
    step(1, 1, 32'h200, 0);
    chk("t6_valid", 32'(if_valid), 32'd0);
    chk("t6_instr", instr, 32'd0);
    chk("t6_pc4",   pc4, 32'd0);
    chk("t6_req",   32'(imem_req), 32'd1);
    chk("t6_addr",  imem_addr, RESET_PC);

    // Random traffic
    lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          r, ps, st;
      logic [31:0] ba;
      r  = ($urandom_range(0, 199) == 0);
      ps = ($urandom_range(0, 99) < 8);
      st = ($urandom_range(0, 99) < 30);
      ba = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom;
      step(r, ps, ba, st);
    end

    chk_en = 1'b0;
    $display("final fetch state code %0d", state_dbg);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
